// File: rtl/lcd_text_refresh.sv
// rtl/lcd_text_refresh.sv - Replays a 32-byte text buffer to a 2x16 character LCD controller over Avalon-MM
module lcd_text_refresh #(
   parameter logic [7:0] BLANK_CHAR   = 8'h20,
   parameter logic       AUTO_REFRESH = 1'b1,
   parameter logic [7:0] LINE1_CMD    = 8'h80,
   parameter logic [7:0] LINE2_CMD    = 8'hC0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       char_we,
   input  logic [4:0] char_addr,
   input  logic [7:0] char_data,
   input  logic       refresh,
   output logic       busy,
   output logic       done,
   output logic       avm_address,
   output logic       avm_chipselect,
   output logic       avm_write,
   output logic       avm_read,
   output logic [7:0] avm_writedata,
   input  logic       avm_waitrequest
);

   localparam logic [5:0] LAST_IDX  = 6'd33;
   localparam logic [5:0] LINE2_IDX = 6'd17;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_buf [32];
   logic       r_pending;
   logic       w_pending_nxt;
   logic [5:0] r_idx;
   logic [5:0] w_idx_nxt;
   logic       r_busy;
   logic       w_busy_nxt;
   logic       r_done;
   logic       w_done_nxt;
   logic       r_cs;
   logic       w_cs_nxt;
   logic       r_addr;
   logic       w_addr_nxt;
   logic [7:0] r_wdata;
   logic [7:0] w_wdata_nxt;
   logic       w_req;
   logic       w_start;
   logic [5:0] w_word_idx;
   logic [4:0] w_buf_sel;
   logic       w_word_addr;
   logic [7:0] w_word_data;

   assign w_req = refresh | (AUTO_REFRESH & char_we);

   // Word for the transaction about to be loaded: idx 0 from IDLE, idx+1 from GAP.
   always_comb begin
      w_word_idx  = (r_state == GAP) ? (r_idx + 6'd1) : 6'd0;
      w_buf_sel   = (w_word_idx <= 6'd16) ? (w_word_idx[4:0] - 5'd1) : (w_word_idx[4:0] - 5'd2);
      w_word_addr = 1'b1;
      w_word_data = r_buf[w_buf_sel];
      if (w_word_idx == 6'd0) begin
         w_word_addr = 1'b0;
         w_word_data = LINE1_CMD;
      end else if (w_word_idx == LINE2_IDX) begin
         w_word_addr = 1'b0;
         w_word_data = LINE2_CMD;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_cs_nxt    = r_cs;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_start     = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_pending) begin
               w_start     = 1'b1;
               w_idx_nxt   = 6'd0;
               w_busy_nxt  = 1'b1;
               w_cs_nxt    = 1'b1;
               w_addr_nxt  = w_word_addr;
               w_wdata_nxt = w_word_data;
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (!avm_waitrequest) begin
               w_cs_nxt    = 1'b0;
               w_state_nxt = GAP;
            end
         end
         GAP: begin
            // One idle cycle lets the controller leave its COMPLETE state.
            if (r_idx == LAST_IDX) begin
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_idx_nxt   = r_idx + 6'd1;
               w_cs_nxt    = 1'b1;
               w_addr_nxt  = w_word_addr;
               w_wdata_nxt = w_word_data;
               w_state_nxt = ISSUE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_idx_nxt   = 6'd0;
            w_busy_nxt  = 1'b0;
            w_cs_nxt    = 1'b0;
            w_addr_nxt  = 1'b0;
            w_wdata_nxt = 8'h00;
         end
      endcase
   end

   assign w_pending_nxt = (r_pending & ~w_start) | w_req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_pending <= 1'b0;
         r_idx     <= 6'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_cs      <= 1'b0;
         r_addr    <= 1'b0;
         r_wdata   <= 8'h00;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_pending_nxt;
         r_idx     <= w_idx_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_cs      <= w_cs_nxt;
         r_addr    <= w_addr_nxt;
         r_wdata   <= w_wdata_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            r_buf[i] <= BLANK_CHAR;
         end
      end else if (char_we) begin
         r_buf[char_addr] <= char_data;
      end
   end

   assign busy           = r_busy;
   assign done           = r_done;
   assign avm_address    = r_addr;
   assign avm_chipselect = r_cs;
   assign avm_write      = r_cs;
   assign avm_read       = 1'b0;
   assign avm_writedata  = r_wdata;

endmodule
